// File: rtl/bpu_pkg.sv
// Shared definitions for the fetch-stage branch predictor.
//   bpu_cnt_e : 2-bit direction counter encodings
//   idx_bits  : BTB index width derived from entry count
//   tag_bits  : BTB tag width derived from PC width and entry count
//   cnt_upd   : saturating counter update on a resolved direction
package bpu_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bpu_cnt_e;

  function automatic int unsigned idx_bits(input int unsigned entries);
    return $clog2(entries);
  endfunction

  // PC bits [1:0] are always zero (word-aligned fetch) and are not tagged.
  function automatic int unsigned tag_bits(input int unsigned width,
                                           input int unsigned entries);
    return width - $clog2(entries) - 2;
  endfunction

  function automatic bpu_cnt_e cnt_upd(input bpu_cnt_e c, input logic taken);
    bpu_cnt_e n;
    n = c;
    if (taken) begin
      case (c)
        SNT:     n = WNT;
        WNT:     n = WT;
        default: n = ST;
      endcase
    end else begin
      case (c)
        ST:      n = WT;
        WT:      n = WNT;
        default: n = SNT;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
//   clk, rst     : clock, synchronous active-high reset (clears valid bits)
//   rd_wpc_i     : word address (pc[WIDTH-1:2]) for the combinational lookup
//   rd_hit_o     : lookup hit
//   rd_taken_o   : hit and counter predicts taken
//   rd_target_o  : stored target for the looked-up entry
//   wr_en_i      : resolved branch/jump to train on this edge
//   wr_wpc_i     : word address of the resolved instruction
//   wr_taken_i   : resolved direction
//   wr_target_i  : resolved target
// The read port sees pre-update contents; updates land on the clock edge.
module bpu_btb
  import bpu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ENTRIES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-3:0] rd_wpc_i,
  output logic             rd_hit_o,
  output logic             rd_taken_o,
  output logic [WIDTH-1:0] rd_target_o,
  input  logic             wr_en_i,
  input  logic [WIDTH-3:0] wr_wpc_i,
  input  logic             wr_taken_i,
  input  logic [WIDTH-1:0] wr_target_i
);

  localparam int unsigned IDX = idx_bits(ENTRIES);
  localparam int unsigned TW  = tag_bits(WIDTH, ENTRIES);

  logic [ENTRIES-1:0]           valid_q;
  logic [ENTRIES-1:0][TW-1:0]   tag_q;
  logic [ENTRIES-1:0][WIDTH-1:0] target_q;
  bpu_cnt_e                      cnt_q [ENTRIES];

  logic [IDX-1:0] rd_idx, wr_idx;
  logic [TW-1:0]  rd_tag, wr_tag;
  logic           wr_hit;

  assign rd_idx = rd_wpc_i[IDX-1:0];
  assign rd_tag = rd_wpc_i[WIDTH-3:IDX];
  assign wr_idx = wr_wpc_i[IDX-1:0];
  assign wr_tag = wr_wpc_i[WIDTH-3:IDX];

  // Tag/target/counter are uninitialised after reset; every consumer is
  // gated by valid_q so nothing undefined reaches the outputs.
  assign rd_hit_o    = valid_q[rd_idx] & (tag_q[rd_idx] == rd_tag);
  assign rd_taken_o  = rd_hit_o & cnt_q[rd_idx][1];
  assign rd_target_o = rd_hit_o ? target_q[rd_idx] : '0;

  assign wr_hit = valid_q[wr_idx] & (tag_q[wr_idx] == wr_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i && !wr_hit && wr_taken_i) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Payload arrays need no reset; the rst guard only discards an update
  // that coincides with reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_en_i) begin
      if (wr_hit) begin
        cnt_q[wr_idx] <= cnt_upd(cnt_q[wr_idx], wr_taken_i);
        if (wr_taken_i) target_q[wr_idx] <= wr_target_i;
      end else if (wr_taken_i) begin
        // Miss allocation overwrites whatever aliased entry lived here.
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= wr_target_i;
        cnt_q[wr_idx]    <= WT;
      end
    end
  end

endmodule

// File: rtl/fetch_bpu.sv
// Fetch stage with BTB-based prediction and D-stage mispredict repair.
//   clk, rst                 : clock, synchronous active-high reset
//   stallF, stallD           : hold fetch PC / suppress D-stage resolution
//   pcF, predtakenF/targetF  : fetch address and its prediction
//   validD, isbrD, pcD       : D-stage instruction info
//   predtakenD/targetD       : prediction carried with the D instruction
//   brtakenD, brtargetD      : resolved outcome
//   mispredictD, redirectpcD : redirect request (also flushes F/D)
//   brcount, mispcount       : saturating performance counters
module fetch_bpu
  import bpu_pkg::*;
#(
  parameter int unsigned       WIDTH       = 32,
  parameter int unsigned       BTB_ENTRIES = 16,
  parameter logic [WIDTH-1:0]  RESET_PC    = 32'h0000_0000,
  parameter int unsigned       CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallF,
  input  logic             stallD,
  output logic [WIDTH-1:0] pcF,
  output logic             predtakenF,
  output logic [WIDTH-1:0] predtargetF,
  input  logic             validD,
  input  logic             isbrD,
  input  logic [WIDTH-1:0] pcD,
  input  logic             predtakenD,
  input  logic [WIDTH-1:0] predtargetD,
  input  logic             brtakenD,
  input  logic [WIDTH-1:0] brtargetD,
  output logic             mispredictD,
  output logic [WIDTH-1:0] redirectpcD,
  output logic [CNT_W-1:0] brcount,
  output logic [CNT_W-1:0] mispcount
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] brcnt_q, mispcnt_q;
  logic             hitF;
  logic [WIDTH-1:0] btb_tgtF;
  logic             resolve;
  logic             br_res;

  assign resolve = validD & ~stallD;
  assign br_res  = resolve & isbrD;

  bpu_btb #(
    .WIDTH   (WIDTH),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .rd_wpc_i    (pc_q[WIDTH-1:2]),
    .rd_hit_o    (hitF),
    .rd_taken_o  (predtakenF),
    .rd_target_o (btb_tgtF),
    .wr_en_i     (br_res),
    .wr_wpc_i    (pcD[WIDTH-1:2]),
    .wr_taken_i  (brtakenD),
    .wr_target_i (brtargetD)
  );

  assign pcF         = pc_q;
  assign predtargetF = hitF ? btb_tgtF : pc_q + WIDTH'(4);

  // A non-branch that was predicted taken is an alias hit and must be undone.
  assign mispredictD = resolve & (isbrD ?
                         ((brtakenD != predtakenD) |
                          (brtakenD & (brtargetD != predtargetD))) :
                         predtakenD);
  assign redirectpcD = (isbrD & brtakenD) ? brtargetD : pcD + WIDTH'(4);

  // Redirect beats stallF: the held instruction is on the wrong path anyway.
  always_comb begin
    pc_d = pc_q + WIDTH'(4);
    if (mispredictD)     pc_d = redirectpcD;
    else if (stallF)     pc_d = pc_q;
    else if (predtakenF) pc_d = predtargetF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      brcnt_q   <= '0;
      mispcnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (br_res && brcnt_q != '1)        brcnt_q   <= brcnt_q + CNT_W'(1);
      if (mispredictD && mispcnt_q != '1) mispcnt_q <= mispcnt_q + CNT_W'(1);
    end
  end

  assign brcount   = brcnt_q;
  assign mispcount = mispcnt_q;

endmodule

// File: tb/tb_fetch_bpu.sv
module tb_fetch_bpu;

  logic        clk = 1'b0;
  logic        rst, stallF, stallD;
  logic [31:0] pcF, predtargetF, pcD, predtargetD, brtargetD, redirectpcD;
  logic        predtakenF, validD, isbrD, predtakenD, brtakenD, mispredictD;
  logic [31:0] brcount, mispcount;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_bpu #(
    .WIDTH(32), .BTB_ENTRIES(16), .RESET_PC(32'h0), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD),
    .pcF(pcF), .predtakenF(predtakenF), .predtargetF(predtargetF),
    .validD(validD), .isbrD(isbrD), .pcD(pcD),
    .predtakenD(predtakenD), .predtargetD(predtargetD),
    .brtakenD(brtakenD), .brtargetD(brtargetD),
    .mispredictD(mispredictD), .redirectpcD(redirectpcD),
    .brcount(brcount), .mispcount(mispcount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    validD = 0; isbrD = 0; pcD = 0; predtakenD = 0; predtargetD = 0;
    brtakenD = 0; brtargetD = 0;
  endtask

  task automatic res(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt);
    validD = 1; isbrD = 1; pcD = pc; brtakenD = tk; brtargetD = tgt;
    predtakenD = ptk; predtargetD = ptgt;
    #1;
  endtask

  // Steers fetch to an address using a non-branch alias redirect (pcD+4).
  task automatic go(input logic [31:0] a);
    validD = 1; isbrD = 0; pcD = a - 32'd4; predtakenD = 1; brtakenD = 0;
    step();
    clr();
    #1;
    chk("go_pcF", pcF, a);
  endtask

  initial begin
    rst = 1; stallF = 0; stallD = 0;
    clr();
    // 1. reset
    step(); step();
    chk("rst_pc", pcF, 32'h0);
    chk("rst_ptk", {31'b0, predtakenF}, 32'h0);
    chk("rst_br", brcount, 32'h0);
    chk("rst_misp", mispcount, 32'h0);
    chk("rst_mispD", {31'b0, mispredictD}, 32'h0);
    rst = 0;
    step(); chk("seq_4", pcF, 32'h4);
    step(); chk("seq_8", pcF, 32'h8);
    step(); chk("seq_c", pcF, 32'hC);

    // 2. cold taken branch
    res(32'h10, 1, 32'h40, 0, 32'h14);
    chk("cold_misp", {31'b0, mispredictD}, 32'h1);
    chk("cold_rpc", redirectpcD, 32'h40);
    step(); clr();
    chk("cold_pc", pcF, 32'h40);
    chk("cold_br", brcount, 32'd1);
    chk("cold_mc", mispcount, 32'd1);
    go(32'h10);
    chk("tr_ptk", {31'b0, predtakenF}, 32'h1);
    chk("tr_ptgt", predtargetF, 32'h40);
    step(); chk("tr_follow", pcF, 32'h40);

    // 3. counter training: WT -> WNT
    res(32'h10, 0, 32'h0, 1, 32'h40);
    chk("nt_misp", {31'b0, mispredictD}, 32'h1);
    chk("nt_rpc", redirectpcD, 32'h14);
    step(); clr();
    chk("nt_pc", pcF, 32'h14);
    go(32'h10);
    chk("wnt_ptk", {31'b0, predtakenF}, 32'h0);
    step(); chk("wnt_fall", pcF, 32'h14);
    // four taken resolves under stallF: WNT->WT->ST->ST->ST
    stallF = 1;
    res(32'h10, 1, 32'h40, 1, 32'h40);
    chk("ok_misp", {31'b0, mispredictD}, 32'h0);
    repeat (4) step();
    clr();
    chk("stall_hold", pcF, 32'h14);
    chk("tr_br", brcount, 32'd6);
    chk("tr_mc", mispcount, 32'd4);
    stallF = 0;
    // one not-taken from ST lands on WT (still taken) if it saturated
    res(32'h10, 0, 32'h0, 1, 32'h40);
    step(); clr();
    go(32'h10);
    chk("sat_ptk", {31'b0, predtakenF}, 32'h1);
    chk("sat_br", brcount, 32'd7);
    chk("sat_mc", mispcount, 32'd6);

    // 4. aliasing at index 4
    go(32'h50);
    chk("al_miss", {31'b0, predtakenF}, 32'h0);
    chk("al_tgt", predtargetF, 32'h54);
    res(32'h50, 1, 32'h80, 0, 32'h54);
    step(); clr();
    chk("al_pc", pcF, 32'h80);
    go(32'h10);
    chk("al_old_ptk", {31'b0, predtakenF}, 32'h0);
    chk("al_old_tgt", predtargetF, 32'h14);
    go(32'h50);
    chk("al_new_ptk", {31'b0, predtakenF}, 32'h1);
    chk("al_new_tgt", predtargetF, 32'h80);

    // 5. priority: redirect beats stallF
    stallF = 1;
    res(32'h50, 0, 32'h0, 1, 32'h80);   // entry 4 WT -> WNT
    step(); clr();
    chk("pri_pc", pcF, 32'h54);
    chk("pri_mc", mispcount, 32'd11);
    // stallD suppresses resolution entirely
    stallD = 1;
    res(32'h50, 1, 32'h80, 0, 32'h54);
    chk("sd_misp", {31'b0, mispredictD}, 32'h0);
    step(); clr();
    chk("sd_pc", pcF, 32'h54);
    chk("sd_br", brcount, 32'd9);
    chk("sd_mc", mispcount, 32'd11);
    stallD = 0; stallF = 0;
    go(32'h50);
    chk("sd_noupd", {31'b0, predtakenF}, 32'h0);

    // 6. reset mid-run with a taken resolve in the same cycle
    stallF = 1;
    res(32'h50, 1, 32'h80, 1, 32'h80);  // WNT -> WT, no mispredict
    step(); clr();
    chk("pre_ptk", {31'b0, predtakenF}, 32'h1);
    stallF = 0;
    rst = 1;
    res(32'h10, 1, 32'h40, 0, 32'h14);
    step(); clr();
    rst = 0;
    #1;
    chk("mr_pc", pcF, 32'h0);
    chk("mr_br", brcount, 32'h0);
    chk("mr_mc", mispcount, 32'h0);
    go(32'h50);
    chk("mr_inv50", {31'b0, predtakenF}, 32'h0);
    chk("mr_tgt50", predtargetF, 32'h54);
    go(32'h10);
    chk("mr_inv10", {31'b0, predtakenF}, 32'h0);

    // +4 wraps modulo 2^32
    go(32'hFFFF_FFFC);
    step();
    chk("wrap", pcF, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_bpu.md
Name: fetch_bpu

Overview:
- Parametrised fetch stage for the 5-stage pipeline. Generalises the fixed PC register, +4 adder and branch/jump PC muxes.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters, so taken branches and jumps redirect fetch in F.
- Branch resolution stays in D, as in the existing pipeline. When D disagrees with the prediction, this block raises a redirect/flush and repairs the PC.
- Also keeps saturating performance counters for resolved branches and mispredicts.

Parameters:
- WIDTH, 32: PC/address width in bits.
- BTB_ENTRIES, 16: number of BTB entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset, sampled on posedge clk.
- stallF  in  1  hold pcF.
- stallD  in  1  D stage stalled; resolution inputs are ignored while high.
- pcF  out  WIDTH  current fetch address.
- predtakenF  out  1  prediction for pcF; travels with the instruction to D.
- predtargetF  out  WIDTH  predicted target for pcF; travels with the instruction to D.
- validD  in  1  D holds a real instruction (not a bubble).
- isbrD  in  1  D instruction is a branch or jump.
- pcD  in  WIDTH  address of the D instruction.
- predtakenD, predtargetD  in  1, WIDTH  prediction carried to D.
- brtakenD  in  1  resolved direction (1 for jumps).
- brtargetD  in  WIDTH  resolved target.
- mispredictD  out  1  redirect; also flushes the F/D register.
- redirectpcD  out  WIDTH  corrected PC.
- brcount  out  CNT_W  count of resolved branches.
- mispcount  out  CNT_W  count of mispredicts.

Behaviour:
- Definitions:
  - IDX = log2(BTB_ENTRIES).
  - index = pc[IDX+1:2].
  - tag = pc[WIDTH-1:IDX+2].
  - resolve = validD & ~stallD.
- Lookup (combinational on pcF):
  - hit = valid[index] & (tag_mem[index] == tag(pcF)).
  - predtakenF = hit & cnt[index][1].
  - predtargetF = hit ? target[index] : pcF+4.
- Mispredict (combinational):
  - mispredictD = resolve & (isbrD ? (brtakenD != predtakenD) | (brtakenD & brtargetD != predtargetD) : predtakenD).
  - redirectpcD = (isbrD & brtakenD) ? brtargetD : pcD+4.
- Next PC, in priority order:
  1. rst → RESET_PC.
  2. mispredictD → redirectpcD. This overrides stallF.
  3. stallF → hold.
  4. predtakenF → predtargetF.
  5. otherwise → pcF+4.
- BTB update at posedge, when resolve & isbrD & ~rst, at index(pcD):
  - Hit, taken: counter increments, saturating at 11; target is written with brtargetD.
  - Hit, not taken: counter decrements, saturating at 00; target is unchanged.
  - Miss, taken: allocate the entry (valid=1, tag, target=brtargetD, counter=10 WT). Replaces any aliased entry.
  - Miss, not taken: no change.
- Non-branch predicted taken (an alias hit on a non-branch): no BTB update, but the mispredict redirect still fires.
- Read-before-write: a lookup in the same cycle as an update to the same index sees the pre-update contents.
- Reset:
  - pcF = RESET_PC.
  - All valid bits cleared. Tag, target and counter contents are don't-care, but simulation must show no X on outputs.
  - brcount = mispcount = 0.
  - mispredictD is combinational and therefore 0 whenever validD=0.
  - Reset mid-operation discards any update in that cycle.
- Counters:
  - brcount increments on resolve & isbrD.
  - mispcount increments on mispredictD.
  - Both saturate at all-ones; no wrap.
- Latency:
  - Prediction is zero-cycle (same cycle as pcF).
  - Redirect penalty is 1 cycle: one flushed F/D slot.
  - A BTB update is visible to lookups from the next cycle.
- Arithmetic: +4 is computed modulo 2^WIDTH and wraps silently.

Decomposition:
- Package bpu_pkg holds:
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - the saturating inc/dec function;
  - the index/tag width derivation.
- One sub-module, bpu_btb, contains:
  - the valid/tag/target/counter arrays;
  - the combinational read port;
  - the synchronous write/update port with reset-clear of valid bits.
- fetch_bpu itself holds the PC register, next-PC priority mux, mispredict logic and performance counters.

Test Plan (RESET_PC=0, BTB_ENTRIES=16, WIDTH=32):
1. Reset sequence: rst high 2 cycles, then low, no branches → pcF = 0, 4, 8, 0xC; predtakenF=0; brcount = mispcount = 0.
2. Cold taken branch: pcD=0x10, isbrD=1, brtakenD=1, brtargetD=0x40, predtakenD=0 → mispredictD=1, redirectpcD=0x40, next pcF=0x40; BTB[4] becomes valid with counter WT; mispcount=1. Next fetch of 0x10 → predtakenF=1, predtargetF=0x40.
3. Counter training: entry at 0x10 in WT; resolve not-taken once → counter WNT; next fetch of 0x10 predicts not taken, predtargetF=0x14. Four further taken resolves → counter saturates at ST, no wrap.
4. Aliasing: entry for 0x10 valid; fetch pcF=0x50 (same index 4, different tag) → miss, predtakenF=0. Resolve 0x50 taken to 0x80 → entry 4 replaced; fetch of 0x10 now misses.
5. Priority: stallF=1 together with mispredictD=1 → pcF = redirectpcD next cycle. stallD=1 with the same resolve inputs → no mispredict, no BTB update, counters unchanged.
6. Reset mid-run: rst asserted in the same cycle as a taken resolve → pcF=0, all entries invalid (previously trained 0x10 now misses), update discarded, counters 0.
